contador_updown_param: RTL
==========================

// Module: contador_updown_param
// PURPOSE
//   Parametrised up/down counter; successor of the fixed 4-bit button counter.
//   Generic width and top value, wrap or saturate mode, optional edge detection on up/down,
//   synchronous parallel load, and carry/borrow pulses for cascading or display logic.
//   Sits between debounced push-button inputs and the display/decoder stage.
// PARAMETERS
//   WIDTH     4   counter width in bits
//   MAX       15  top count; range is 0..MAX; elaboration error if MAX > 2**WIDTH-1 or MAX == 0
//   SATURATE  0   0: wrap at the limits; 1: hold at 0 / MAX
//   EDGE_MODE 1   1: count once per rising edge of up/down; 0: count every enabled cycle while level high
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous reset, active-high
//   enable      in   1      count enable; gates up/down events only
//   up          in   1      increment request
//   down        in   1      decrement request
//   load        in   1      synchronous parallel load
//   load_value  in   WIDTH  value for load
//   numero      out  WIDTH  current count, registered
//   carry       out  1      registered 1-cycle pulse on wrap MAX->0
//   borrow      out  1      registered 1-cycle pulse on wrap 0->MAX
//   at_max      out  1      combinational: numero == MAX
//   at_min      out  1      combinational: numero == 0
// BEHAVIOUR
//   Reset (async, immediate): numero=0, carry=0, borrow=0, up_q=0, down_q=0.
//   Edge detect (EDGE_MODE=1): up_q/down_q register up/down every clk regardless of enable/load.
//     up_ev = up & ~up_q; dn_ev = down & ~down_q. EDGE_MODE=0: up_ev = up; dn_ev = down.
//   Priority per rising clk edge:
//     1. load=1: numero <= min(load_value, MAX); enable ignored; carry=borrow=0.
//     2. enable=0: numero holds.
//     3. up_ev & dn_ev: numero holds (simultaneous requests cancel).
//     4. up_ev: numero<MAX -> +1; numero==MAX -> wrap to 0 with carry=1 (SATURATE=0),
//        or hold at MAX with carry=0 (SATURATE=1).
//     5. dn_ev: numero>0 -> -1; numero==0 -> wrap to MAX with borrow=1 (SATURATE=0),
//        or hold at 0 with borrow=0 (SATURATE=1).
//     6. No event: numero holds.
//   carry/borrow: high for exactly the one cycle following the wrapping edge, 0 otherwise.
//   Latency: request sampled at edge N -> numero updated after edge N (one edge); in
//     EDGE_MODE=1 a request held high for many cycles yields exactly one step.
//   Arithmetic: modulo MAX+1, not 2**WIDTH; numero is never > MAX.
//   Reset mid-operation: clears immediately; with up still held at release, up_q=0, so
//     the first edge after release counts once (EDGE_MODE=1).
//   Rising edge while enable=0 is lost; no pending event is stored.
// TESTING
//   T1 reset: rst=1 with up toggling -> numero=0, carry=borrow=0, at_min=1 throughout.
//   T2 edge count (WIDTH=4, MAX=15, wrap): 16 up pulses (1 high, 1 low cycle each) ->
//      numero 1..15 then 0, carry high one cycle at 15->0; up held 10 cycles -> +1 only.
//   T3 down wrap: from 0, one down pulse -> numero=15, borrow one cycle; up=down rising
//      together -> numero unchanged.
//   T4 decade (MAX=9), SATURATE=1: 12 up pulses -> stops at 9, carry never asserts;
//      12 down pulses -> stops at 0, borrow never asserts.
//   T5 load: load=1, load_value=7 with enable=0 -> numero=7 next edge; load_value=12 with
//      MAX=9 -> numero=9; load with simultaneous up edge -> load wins.
//   T6 level mode (EDGE_MODE=0): up held 5 enabled cycles from 3 -> numero=8; async rst
//      asserted between edges -> numero=0 before the next clk edge.

Source files
------------

// File: rtl/contador_updown_param.sv
// Parametrised up/down counter with wrap/saturate, optional edge detection on up/down,
// synchronous load and registered carry/borrow pulses for cascading.
module contador_updown_param #(
    parameter int WIDTH     = 4,
    parameter int MAX       = 15,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] numero,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min
);

    generate
        if (MAX <= 0 || (WIDTH < 31 && MAX > (2 ** WIDTH) - 1)) begin : g_bad_max
            $error("contador_updown_param: MAX must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] numero_q, numero_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             up_q, down_q;
    logic             up_ev, dn_ev;

    // Edge history is tracked every cycle, independent of enable/load, so an
    // edge arriving while disabled is consumed rather than deferred.
    assign up_ev = (EDGE_MODE != 0) ? (up & ~up_q)     : up;
    assign dn_ev = (EDGE_MODE != 0) ? (down & ~down_q) : down;

    always_comb begin
        numero_d = numero_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            numero_d = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (enable && (up_ev != dn_ev)) begin
            if (up_ev) begin
                if (numero_q != MAX_V) begin
                    numero_d = numero_q + 1'b1;
                end else if (SATURATE == 0) begin
                    numero_d = '0;
                    carry_d  = 1'b1;
                end
            end else begin
                if (numero_q != '0) begin
                    numero_d = numero_q - 1'b1;
                end else if (SATURATE == 0) begin
                    numero_d = MAX_V;
                    borrow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            numero_q <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            numero_q <= numero_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            up_q     <= up;
            down_q   <= down;
        end
    end

    assign numero = numero_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign at_max = (numero_q == MAX_V);
    assign at_min = (numero_q == '0);

endmodule
